ttt_game_ctrl: RTL and testbench
================================

# ttt_game_ctrl

Game-state controller for the tic-tac-toe VGA design. It accepts player moves, keeps the 3x3 board and alternates turns, and detects a win or a draw. It drives the `occupied`/`symbol` vectors that the board renderer reads every pixel. Board outputs change only during video blanking, so a frame never shows a half-applied move.

## Interface
Parameters:
- none; the board is fixed at 9 cells, with cell index j = 3*row + col (row 0 = top, col 0 = left).

Ports:
- `clk`  in  1  system/pixel clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `visible`  in  1  high during the active video area, from the VGA timing generator.
- `new_game`  in  1  one-cycle pulse; clears the board and starts a new game.
- `move_valid`  in  1  one-cycle pulse; the current player requests cell `move_pos`.
- `move_pos`  in  4  requested cell, 0..8.
- `move_ready`  out  1  high when a move can be accepted; equals (state == WAIT).
- `illegal`  out  1  one-cycle pulse; the last request was rejected.
- `turn`  out  1  player to move: 0 = X, 1 = O.
- `game_over`  out  1  high in state OVER.
- `winner`  out  2  00 = none, 01 = X, 10 = O, 11 = draw.
- `move_count`  out  4  number of cells filled, 0..9.
- `occupied`  out  9  displayed board; bit j = cell j is filled.
- `symbol`  out  9  displayed symbols; bit j = 0 for X, 1 for O. Meaningful only where `occupied[j]` is set.

## Operation
- Internal board registers `b_occ[8:0]` and `b_sym[8:0]` hold the true game state.
- `occupied`/`symbol` are shadow registers. They load from `b_occ`/`b_sym` on every clock edge where `visible` = 0, and hold while `visible` = 1.
- State machine, with states WAIT, CHECK and OVER:
  - WAIT: on `move_valid`, check the request.
    - Illegal request (`move_pos` > 8, or `b_occ[move_pos]` = 1): pulse `illegal`; stay in WAIT; nothing else changes.
    - Legal request: set `b_occ[move_pos]` = 1 and `b_sym[move_pos]` = `turn`; increment `move_count`; go to CHECK.
  - CHECK: evaluate the 8 lines: rows {0,1,2}, {3,4,5}, {6,7,8}; columns {0,3,6}, {1,4,7}, {2,5,8}; diagonals {0,4,8}, {2,4,6}. A line is won by the mover when all 3 cells are occupied with symbol == `turn`.
    - Mover wins: `winner` = `turn` + 1 (01 or 10); go to OVER; `turn` holds.
    - No win and `move_count` = 9: `winner` = 11; go to OVER.
    - Otherwise: toggle `turn`; go to WAIT.
  - OVER: `move_valid` is ignored, with no `illegal` pulse and no state change. Only `new_game` or reset exits.
- `new_game` is honoured in any state and overrides a simultaneous `move_valid`. On the next edge it clears `b_occ`, `b_sym`, `move_count`, `winner` and `turn`, and sets state to WAIT. The shadow outputs clear at the next blanking edge.
- `move_valid` during CHECK cannot occur legally, because `move_ready` = 0. If it does occur, it is ignored with no `illegal` pulse.
- A win on the 9th move reports the mover, never a draw.

## Timing
- Reset (asynchronous, `reset` = 0): state = WAIT. All of these are 0: `move_ready` is 1; `illegal`, `turn`, `game_over`, `winner`, `move_count`, `occupied`, `symbol`, `b_occ`, `b_sym`.
- A legal move accepted at edge N:
  - `b_occ`/`b_sym`/`move_count` update at edge N.
  - `move_ready` = 0 for one cycle.
  - At edge N+1: `turn`, `winner` and `game_over` update; state returns to WAIT or goes to OVER.
- A sustained move rate of one move per 2 cycles is supported.
- `illegal` is asserted for exactly the one cycle after the rejecting edge.
- Display latency: `occupied`/`symbol` reflect a move at the first edge with `visible` = 0 at or after the update. This can be up to one full active frame later.
- Reset asserted mid-game or mid-CHECK aborts immediately. There is no partial commit.

## Test plan
- Reset, then hold `visible` = 0. Move X@4 -> `occupied` = 9'b000010000, `symbol` = 0, `turn` = 1, `move_ready` high again 2 cycles after the request.
- X@0, O@0 -> `illegal` pulses once; `turn` stays 1; `move_count` = 1. Also `move_pos` = 12 -> `illegal` pulses; board unchanged.
- X@0, O@3, X@1, O@4, X@2 -> `winner` = 01, `game_over` = 1, `turn` = 0. A further move is ignored and `illegal` stays 0.
- Full-board draw sequence X4, O0, X2, O6, X3, O5, X8, O1, X7 -> `move_count` = 9, `winner` = 11.
- Move made with `visible` = 1 held for 1000 cycles -> `occupied` unchanged throughout. It updates on the first cycle with `visible` = 0.
- In OVER, `new_game` and `move_valid` in the same cycle -> board cleared, `winner` = 00, state WAIT, `move_count` = 0. Then assert `reset` low mid-CHECK -> all outputs 0 immediately.

Source files
------------

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game-state controller: accepts moves, alternates turns, detects win/draw,
// and presents a board snapshot that only changes while video is blanked.
module ttt_game_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       visible,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic       illegal,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] move_count,
  output logic [8:0] occupied,
  output logic [8:0] symbol
);

  typedef enum logic [1:0] {StWait, StCheck, StOver} state_e;

  state_e     state_q;
  logic [8:0] b_occ_q;
  logic [8:0] b_sym_q;

  logic [8:0] cell_mask;
  logic       pos_legal;
  logic [8:0] mine;
  logic       mover_wins;

  // Out-of-range positions shift the bit off the end, giving an empty mask.
  assign cell_mask = 9'(16'd1 << move_pos);
  assign pos_legal = (move_pos <= 4'd8) && ((b_occ_q & cell_mask) == 9'd0);

  // Cells held by the player who just moved.
  assign mine = b_occ_q & (turn ? b_sym_q : ~b_sym_q);

  assign mover_wins = (&mine[2:0]) | (&mine[5:3]) | (&mine[8:6]) |
                      (mine[0] & mine[3] & mine[6]) |
                      (mine[1] & mine[4] & mine[7]) |
                      (mine[2] & mine[5] & mine[8]) |
                      (mine[0] & mine[4] & mine[8]) |
                      (mine[2] & mine[4] & mine[6]);

  assign move_ready = (state_q == StWait);
  assign game_over  = (state_q == StOver);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StWait;
      b_occ_q    <= 9'd0;
      b_sym_q    <= 9'd0;
      illegal    <= 1'b0;
      turn       <= 1'b0;
      winner     <= 2'b00;
      move_count <= 4'd0;
      occupied   <= 9'd0;
      symbol     <= 9'd0;
    end else begin
      illegal <= 1'b0;

      if (!visible) begin
        occupied <= b_occ_q;
        symbol   <= b_sym_q;
      end

      if (new_game) begin
        state_q    <= StWait;
        b_occ_q    <= 9'd0;
        b_sym_q    <= 9'd0;
        turn       <= 1'b0;
        winner     <= 2'b00;
        move_count <= 4'd0;
      end else begin
        case (state_q)
          StWait: begin
            if (move_valid) begin
              if (pos_legal) begin
                b_occ_q    <= b_occ_q | cell_mask;
                b_sym_q    <= turn ? (b_sym_q | cell_mask) : (b_sym_q & ~cell_mask);
                move_count <= move_count + 4'd1;
                state_q    <= StCheck;
              end else begin
                illegal <= 1'b1;
              end
            end
          end
          StCheck: begin
            if (mover_wins) begin
              winner  <= turn ? 2'b10 : 2'b01;
              state_q <= StOver;
            end else if (move_count == 4'd9) begin
              winner  <= 2'b11;
              state_q <= StOver;
            end else begin
              turn    <= ~turn;
              state_q <= StWait;
            end
          end
          StOver: begin
            state_q <= StOver;
          end
          default: begin
            state_q <= StWait;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl.
module tb_ttt_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       visible;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;
  logic       illegal;
  logic       turn;
  logic       game_over;
  logic [1:0] winner;
  logic [3:0] move_count;
  logic [8:0] occupied;
  logic [8:0] symbol;

  int n_pass  = 0;
  int n_total = 0;

  ttt_game_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .visible   (visible),
    .new_game  (new_game),
    .move_valid(move_valid),
    .move_pos  (move_pos),
    .move_ready(move_ready),
    .illegal   (illegal),
    .turn      (turn),
    .game_over (game_over),
    .winner    (winner),
    .move_count(move_count),
    .occupied  (occupied),
    .symbol    (symbol)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_move(input logic [3:0] pos);
    move_valid = 1'b1;
    move_pos   = pos;
    tick();
    move_valid = 1'b0;
    tick();
  endtask

  task automatic start_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(move_ready), 32'd1);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_turn"}, 32'(turn), 32'd0);
    chk({tag, "_over"}, 32'(game_over), 32'd0);
    chk({tag, "_winner"}, 32'(winner), 32'd0);
    chk({tag, "_count"}, 32'(move_count), 32'd0);
    chk({tag, "_occ"}, 32'(occupied), 32'd0);
    chk({tag, "_sym"}, 32'(symbol), 32'd0);
  endtask

  initial begin
    int bad;
    reset      = 1'b0;
    visible    = 1'b0;
    new_game   = 1'b0;
    move_valid = 1'b0;
    move_pos   = 4'd0;
    #3;
    chk_all_zero("reset");
    tick();
    reset = 1'b1;
    tick();

    // X@4: board register updates at the accept edge, display one edge later
    move_valid = 1'b1;
    move_pos   = 4'd4;
    tick();
    move_valid = 1'b0;
    chk("x4_ready_low", 32'(move_ready), 32'd0);
    chk("x4_count", 32'(move_count), 32'd1);
    chk("x4_turn_hold", 32'(turn), 32'd0);
    tick();
    chk("x4_ready_back", 32'(move_ready), 32'd1);
    chk("x4_turn", 32'(turn), 32'd1);
    chk("x4_occ", 32'(occupied), 32'h010);
    chk("x4_sym", 32'(symbol), 32'h000);

    // Illegal requests: occupied cell, then out-of-range position
    start_game();
    chk("ng_count", 32'(move_count), 32'd0);
    chk("ng_turn", 32'(turn), 32'd0);
    do_move(4'd0);
    move_valid = 1'b1;
    move_pos   = 4'd0;
    tick();
    move_valid = 1'b0;
    chk("dup_illegal", 32'(illegal), 32'd1);
    chk("dup_ready", 32'(move_ready), 32'd1);
    tick();
    chk("dup_illegal_drop", 32'(illegal), 32'd0);
    chk("dup_turn", 32'(turn), 32'd1);
    chk("dup_count", 32'(move_count), 32'd1);
    move_valid = 1'b1;
    move_pos   = 4'd12;
    tick();
    move_valid = 1'b0;
    chk("oob_illegal", 32'(illegal), 32'd1);
    tick();
    chk("oob_illegal_drop", 32'(illegal), 32'd0);
    chk("oob_occ", 32'(occupied), 32'h001);
    chk("oob_count", 32'(move_count), 32'd1);

    // X wins on the top row
    start_game();
    do_move(4'd0);
    do_move(4'd3);
    do_move(4'd1);
    do_move(4'd4);
    do_move(4'd2);
    chk("xwin_winner", 32'(winner), 32'd1);
    chk("xwin_over", 32'(game_over), 32'd1);
    chk("xwin_turn", 32'(turn), 32'd0);
    chk("xwin_ready", 32'(move_ready), 32'd0);
    chk("xwin_count", 32'(move_count), 32'd5);
    chk("xwin_occ", 32'(occupied), 32'h01F);
    chk("xwin_sym", 32'(symbol), 32'h018);
    move_valid = 1'b1;
    move_pos   = 4'd5;
    tick();
    move_valid = 1'b0;
    chk("over_no_illegal", 32'(illegal), 32'd0);
    tick();
    chk("over_count", 32'(move_count), 32'd5);
    chk("over_occ", 32'(occupied), 32'h01F);
    chk("over_still", 32'(game_over), 32'd1);

    // new_game beats a simultaneous move while in OVER
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_pos   = 4'd5;
    tick();
    new_game   = 1'b0;
    move_valid = 1'b0;
    chk("ngov_winner", 32'(winner), 32'd0);
    chk("ngov_count", 32'(move_count), 32'd0);
    chk("ngov_over", 32'(game_over), 32'd0);
    chk("ngov_ready", 32'(move_ready), 32'd1);
    tick();
    chk("ngov_occ", 32'(occupied), 32'h000);

    // Full-board draw
    do_move(4'd4);
    do_move(4'd0);
    do_move(4'd2);
    do_move(4'd6);
    do_move(4'd3);
    do_move(4'd5);
    do_move(4'd8);
    do_move(4'd1);
    do_move(4'd7);
    chk("draw_count", 32'(move_count), 32'd9);
    chk("draw_winner", 32'(winner), 32'd3);
    chk("draw_over", 32'(game_over), 32'd1);
    chk("draw_turn", 32'(turn), 32'd0);
    chk("draw_occ", 32'(occupied), 32'h1FF);
    chk("draw_sym", 32'(symbol), 32'h063);

    // Display frozen while visible
    start_game();
    chk("vis_pre_occ", 32'(occupied), 32'h000);
    visible = 1'b1;
    do_move(4'd4);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (occupied !== 9'h000) bad++;
      tick();
    end
    chk("vis_hold", 32'(bad), 32'd0);
    chk("vis_board_count", 32'(move_count), 32'd1);
    visible = 1'b0;
    tick();
    chk("vis_release_occ", 32'(occupied), 32'h010);

    // Reset asserted mid-CHECK clears everything at once
    move_valid = 1'b1;
    move_pos   = 4'd0;
    tick();
    move_valid = 1'b0;
    chk("rst_in_check", 32'(move_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    reset = 1'b1;
    tick();
    do_move(4'd4);
    chk("post_rst_count", 32'(move_count), 32'd1);
    chk("post_rst_occ", 32'(occupied), 32'h010);
    chk("post_rst_turn", 32'(turn), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
